// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes common to the control decoder and the
// execute-stage ALU, plus the width constants and FSM state encoding.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: loads an operand on start, then shifts one position per
// cycle; done flags the cycle whose edge applies the last shift (dout).
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift_left,
  input  logic               arith,
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    dout
);

  logic               busy_q, busy_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    shreg_q, shreg_d;
  logic               left_q, left_d;
  logic               fill_q, fill_d;
  logic [XLEN-1:0]    shifted;

  always_comb begin
    shifted = left_q ? {shreg_q[XLEN-2:0], 1'b0} : {fill_q, shreg_q[XLEN-1:1]};
  end

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    left_d  = left_q;
    fill_d  = fill_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = shamt;
      shreg_d = din;
      left_d  = shift_left;
      fill_d  = arith & din[XLEN-1];
    end else if (busy_q) begin
      shreg_d = shifted;
      cnt_d   = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers carry no reset; busy_q gates their use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    left_q  <= left_d;
    fill_q  <= fill_d;
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == SHAMT_W'(1));
  assign dout = shifted;

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle execute ALU: single-cycle logic/arith ops, bit-serial shifts,
// valid/ready handshakes on both sides and registered result/zero/illegal.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            code_illegal;
  logic            code_shift;
  logic [XLEN-1:0] comb_res;
  logic            sh_start, sh_busy, sh_done;
  logic [XLEN-1:0] sh_dout;

  // Shift codes with shamt == 0 fall through to here and return a unchanged.
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] ctrl,
                                             input logic [XLEN-1:0] op_a,
                                             input logic [XLEN-1:0] op_b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = op_a;
    sb = op_b;
    alu_op = '0;
    case (alu_ctrl_e'(ctrl))
      ALU_ADD:  alu_op = op_a + op_b;
      ALU_SUB:  alu_op = op_a - op_b;
      ALU_AND:  alu_op = op_a & op_b;
      ALU_OR:   alu_op = op_a | op_b;
      ALU_XOR:  alu_op = op_a ^ op_b;
      ALU_SLT:  alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: alu_op = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_op = op_a;
      default:  alu_op = '0;
    endcase
  endfunction

  assign in_ready     = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready)) && !sh_busy;
  assign accept       = in_valid && in_ready;
  assign code_illegal = (alu_ctrl > ALU_SLTU);
  assign code_shift   = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
  assign comb_res     = alu_op(alu_ctrl, a, b);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    sh_start    = 1'b0;
    if (state_q == ST_SHIFT) begin
      if (sh_done) begin
        result_d    = sh_dout;
        zero_d      = (sh_dout == '0);
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end else if (accept) begin
      // IDLE, or DONE with the result being consumed this edge.
      if (code_illegal) begin
        result_d    = '0;
        zero_d      = 1'b1;
        illegal_d   = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end else if (code_shift && (b[SHAMT_W-1:0] != '0)) begin
        sh_start    = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ST_SHIFT;
      end else begin
        result_d    = comb_res;
        zero_d      = (comb_res == '0);
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start      (sh_start),
    .shift_left (alu_ctrl == ALU_SLL),
    .arith      (alu_ctrl == ALU_SRA),
    .din        (a),
    .shamt      (b[SHAMT_W-1:0]),
    .busy       (sh_busy),
    .done       (sh_done),
    .dout       (sh_dout)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
